alu_rr_scheduler: RTL and testbench

Shares the single combinational ALU (A, B, 4-bit ALU_Sel, result plus CarryOut) between two requesters using valid/ready handshakes and round-robin arbitration. It registers the winning operands, drives the ALU for one cycle, captures the result and carry, and returns them with the requester ID on a response channel. The block sits between the user-logic front end and the ALU instance inside the tt02 top level.

---
 rtl/alu_rr_scheduler.sv | 153 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between two valid/ready requesters.
// Round-robin arbitration picks the requester that was not granted last. The winner's
// operands are registered onto the ALU for one cycle. The result and carry are captured
// and returned on a response channel, tagged with the requester ID.
module alu_rr_scheduler #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              req1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              pend_id_q, pend_id_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic accept;
    logic winner;

    // Round-robin pick: on a tie the requester not granted last time wins.
    always_comb begin
        accept = (state_q == IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid;
        end
    end

    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;
    assign busy       = (state_q != IDLE);

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pend_id_d    = pend_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = winner;
                    pend_id_d    = winner;
                    alu_a_d      = winner ? req1_a : req0_a;
                    alu_b_d      = winner ? req1_b : req0_b;
                    alu_sel_d    = winner ? req1_sel : req0_sel;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for the whole cycle; sample its output.
                state_d     = RESP;
                rsp_data_d  = alu_out;
                rsp_carry_d = alu_carry;
                rsp_id_d    = pend_id_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; ALU operands persist outside EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            pend_id_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_id_q    <= pend_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: provides a reference ALU, tracks outstanding operations
// at transaction level and compares every DUT output each cycle, plus literal checks.
module tb_alu_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_sel = '0, req1_sel = '0;
    logic       req0_ready, req1_ready;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic       rsp_valid, rsp_id, rsp_carry, busy;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data, op_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.DATA_W(8), .SEL_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .busy(busy), .op_count(op_count)
    );

    // Reference ALU (tt02 style): {carry, result}; carry is always that of A+B.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
        logic [7:0] r;
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, b};
        case (s)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
            4'h4: r = a << 1;
            4'h5: r = a >> 1;
            4'h6: r = {a[6:0], a[7]};
            4'h7: r = {a[0], a[7:1]};
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b);
            4'hC: r = ~(a & b);
            4'hD: r = ~(a ^ b);
            4'hE: r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {t[8], r};
    endfunction

    assign {alu_carry, alu_out} = alu_ref(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation may be outstanding; it is either awaiting its
    // ALU cycle or waiting to be consumed as a response.
    bit         m_inflight = 1'b0;
    logic       m_last = 1'b1;
    logic       m_id = 1'b0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [3:0] m_sel = '0;
    logic       m_rsp_valid = 1'b0, m_rsp_id = 1'b0, m_rsp_carry = 1'b0;
    logic [7:0] m_rsp_data = '0, m_count = '0;

    // bit0 = req0 may go, bit1 = req1 may go
    function automatic logic [1:0] exp_ready();
        if (m_inflight) return 2'b00;
        if (req0_valid && req1_valid) return m_last ? 2'b01 : 2'b10;
        return {req1_valid, req0_valid};
    endfunction

    always @(posedge clk) begin
        logic [1:0] g;
        g = exp_ready();
        if (reset) begin
            m_inflight = 1'b0; m_last = 1'b1; m_rsp_valid = 1'b0; m_rsp_id = 1'b0;
            m_rsp_data = '0; m_rsp_carry = 1'b0; m_count = '0;
            m_a = '0; m_b = '0; m_sel = '0;
        end else if (!m_inflight) begin
            if (g != 2'b00) begin
                m_inflight = 1'b1;
                m_id   = g[1];
                m_last = g[1];
                m_a    = g[1] ? req1_a : req0_a;
                m_b    = g[1] ? req1_b : req0_b;
                m_sel  = g[1] ? req1_sel : req0_sel;
            end
        end else if (!m_rsp_valid) begin
            {m_rsp_carry, m_rsp_data} = alu_ref(m_a, m_b, m_sel);
            m_rsp_id    = m_id;
            m_rsp_valid = 1'b1;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
            m_inflight  = 1'b0;
            m_count     = m_count + 8'd1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [1:0] er;
        if (chk_en) begin
            er = exp_ready();
            chk("req0_ready", 32'(req0_ready), 32'(er[0]));
            chk("req1_ready", 32'(req1_ready), 32'(er[1]));
            chk("busy", 32'(busy), 32'(m_inflight));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_rsp_carry));
            chk("op_count", 32'(op_count), 32'(m_count));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_sel", 32'(alu_sel), 32'(m_sel));
        end
    end

    // Record observed grants for the alternation checks.
    int grants[$];
    always @(negedge clk) begin
        if (req0_valid && req0_ready) grants.push_back(0);
        if (req1_valid && req1_ready) grants.push_back(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Present one operation and hold it until accepted; returns 1 time unit after the
    // accepting edge (i.e. in the EXEC cycle).
    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s);
        int n;
        n = 0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1'b1;
        end
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, report it, and let the handshake edge pass.
    task automatic wait_rsp(output logic [7:0] d, output logic c, output logic i);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(n < 10), 32'd1);
        d = rsp_data; c = rsp_carry; i = rsp_id;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [7:0] sweep_exp [16];
    logic [7:0] d;
    logic       c, i;

    initial begin
        sweep_exp = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

        // Reset values
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        @(posedge clk); #1;

        // Single req0 add; response two cycles after the ready cycle
        req0_a = 8'h0A; req0_b = 8'h02; req0_sel = 4'h0; req0_valid = 1'b1;
        @(negedge clk);
        chk("single_ready0", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        chk("single_rsp_data", 32'(rsp_data), 32'h0C);
        chk("single_rsp_carry", 32'(rsp_carry), 32'd0);
        @(negedge clk);
        chk("single_op_count", 32'(op_count), 32'd1);
        @(posedge clk); #1;

        // Both valid continuously: grants alternate starting with req0
        do_reset();
        grants.delete();
        req0_a = 8'h11; req0_b = 8'h22; req0_sel = 4'h0;
        req1_a = 8'h05; req1_b = 8'h03; req1_sel = 4'h1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        chk("rr_grant_count", 32'(grants.size()), 32'd4);
        if (grants.size() >= 4) begin
            chk("rr_grant0", 32'(grants[0]), 32'd0);
            chk("rr_grant1", 32'(grants[1]), 32'd1);
            chk("rr_grant2", 32'(grants[2]), 32'd0);
            chk("rr_grant3", 32'(grants[3]), 32'd1);
        end
        chk("rr_op_count", 32'(op_count), 32'd4);

        // Carry capture from requester 1
        issue(1'b1, 8'hF6, 8'h0A, 4'h0);
        wait_rsp(d, c, i);
        chk("carry_data", 32'(d), 32'h00);
        chk("carry_carry", 32'(c), 32'd1);
        chk("carry_id", 32'(i), 32'd1);

        // Backpressure with req1 waiting
        rsp_ready = 1'b0;
        issue(1'b0, 8'h33, 8'h11, 4'h1);
        req1_a = 8'h07; req1_b = 8'h01; req1_sel = 4'h8; req1_valid = 1'b1;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h22);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_rsp_carry", 32'(rsp_carry), 32'd0);
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("bp_next_accept", 32'(req1_ready), 32'd1);
        chk("bp_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Reset during EXEC
        issue(1'b1, 8'h01, 8'h01, 4'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_busy", 32'(busy), 32'd0);
        chk("rst_exec_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;

        // Reset during RESP, then a tie must go to req0
        issue(1'b1, 8'h02, 8'h02, 4'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_busy", 32'(busy), 32'd0);
        chk("rst_resp_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_tie_ready0", 32'(req0_ready), 32'd1);
        chk("rst_tie_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Opcode sweep, then wrap op_count
        do_reset();
        for (int k = 0; k < 16; k++) begin
            issue(1'b0, 8'h0A, 8'h02, 4'(k));
            wait_rsp(d, c, i);
            chk("sweep_data", 32'(d), 32'(sweep_exp[k]));
            chk("sweep_carry", 32'(c), 32'd0);
        end
        @(negedge clk);
        chk("sweep_op_count", 32'(op_count), 32'd16);
        @(posedge clk); #1;
        for (int k = 0; k < 240; k++) begin
            issue(1'(k), 8'(k), 8'(k * 3), 4'(k));
            wait_rsp(d, c, i);
        end
        @(negedge clk);
        chk("wrap_op_count", 32'(op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
